// File: rtl/hazard_pkg.sv
// Shared types and helpers for the pipeline hazard controller.
package hazard_pkg;

    typedef enum logic {
        RUN      = 1'b0,
        MDU_BUSY = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_X0 = 5'd0;

    function automatic logic load_use_hit(
        input logic [4:0] rs1,
        input logic [4:0] rs2,
        input logic       uses_rs1,
        input logic       uses_rs2,
        input logic [4:0] rd,
        input logic       is_load
    );
        logic src_hit;
        src_hit = (uses_rs1 && (rs1 == rd)) || (uses_rs2 && (rs2 == rd));
        return is_load && (rd != REG_X0) && src_hit;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline stall/flush control with MDU sequencing and watchdog.
// Optional perf counters are built when HAZARD_CTRL_PERF_EN is defined.
module hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MDU_TIMEOUT = 64,
    parameter int TMO_W       = $clog2(MDU_TIMEOUT + 1),
    parameter int PERF_W      = 32
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [4:0] d_rs1,
    input  logic [4:0] d_rs2,
    input  logic       d_uses_rs1,
    input  logic       d_uses_rs2,
    input  logic [4:0] e_rd,
    input  logic       e_is_load,
    input  logic       e_redirect,
    input  logic       e_mdu_start,
    input  logic       mdu_done,
    output logic       f_enable,
    output logic       fd_enable,
    output logic       fd_flush,
    output logic       de_enable,
    output logic       de_flush,
    output logic       em_flush,
    output logic       mdu_busy,
    output logic       mdu_timeout
`ifdef HAZARD_CTRL_PERF_EN
    ,
    output logic [PERF_W-1:0] stall_cycles,
    output logic [PERF_W-1:0] flush_events
`endif
);

    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MDU_TIMEOUT);

    if (MDU_TIMEOUT < 2 || PERF_W < 1) begin : g_bad_param
        $error("hazard_ctrl: MDU_TIMEOUT must be >= 2 and PERF_W >= 1");
    end

    hz_state_t        state_q;
    hz_state_t        state_d;
    logic [TMO_W-1:0] cnt_q;
    logic [TMO_W-1:0] cnt_d;
    logic             tmo_q;
    logic             tmo_set;
    logic             lu_hit;

    assign lu_hit = load_use_hit(d_rs1, d_rs2, d_uses_rs1, d_uses_rs2,
                                 e_rd, e_is_load);

    always_comb begin
        f_enable  = 1'b1;
        fd_enable = 1'b1;
        fd_flush  = 1'b0;
        de_enable = 1'b1;
        de_flush  = 1'b0;
        em_flush  = 1'b0;
        mdu_busy  = 1'b0;
        tmo_set   = 1'b0;
        state_d   = state_q;
        cnt_d     = cnt_q;
        unique case (state_q)
            RUN: begin
                if (e_redirect) begin
                    fd_flush = 1'b1;
                    de_flush = 1'b1;
                end else if (e_mdu_start && !mdu_done) begin
                    f_enable  = 1'b0;
                    fd_enable = 1'b0;
                    de_enable = 1'b0;
                    em_flush  = 1'b1;
                    state_d   = MDU_BUSY;
                    cnt_d     = TMO_W'(1);
                end else if (e_mdu_start) begin
                    // single-cycle MDU result: flows through like an ALU op
                    state_d = RUN;
                end else if (lu_hit) begin
                    f_enable  = 1'b0;
                    fd_enable = 1'b0;
                    de_flush  = 1'b1;
                end
            end
            MDU_BUSY: begin
                mdu_busy = 1'b1;
                if (mdu_done) begin
                    state_d = RUN;
                    cnt_d   = '0;
                end else if (cnt_q < TMO_MAX) begin
                    f_enable  = 1'b0;
                    fd_enable = 1'b0;
                    de_enable = 1'b0;
                    em_flush  = 1'b1;
                    cnt_d     = cnt_q + TMO_W'(1);
                end else begin
                    // watchdog: drop the MDU result and resume the pipe
                    em_flush = 1'b1;
                    tmo_set  = 1'b1;
                    state_d  = RUN;
                    cnt_d    = '0;
                end
            end
            default: begin
                state_d = RUN;
                cnt_d   = '0;
            end
        endcase
    end

    assign mdu_timeout = tmo_q | tmo_set;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= RUN;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_q | tmo_set;
        end
    end

`ifdef HAZARD_CTRL_PERF_EN
    sat_counter #(
        .W(PERF_W)
    ) u_stall_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (!f_enable),
        .count  (stall_cycles)
    );

    sat_counter #(
        .W(PERF_W)
    ) u_flush_cnt (
        .clk    (clk),
        .reset_n(reset_n),
        .inc    (fd_flush),
        .count  (flush_events)
    );
`else
    // no performance instrumentation in this build
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed + random bench for hazard_ctrl; two instances (timeout 64 and 4)
// checked against a cycle-count reference model.
module tb_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [4:0] d_rs1, d_rs2, e_rd;
    logic       d_uses_rs1, d_uses_rs2, e_is_load;
    logic       e_redirect, e_mdu_start, mdu_done;

    logic [7:0] out_a, out_b;

    int checks = 0;
    int errors = 0;
    string phase = "init";

    // model state: busy cycle number (0 = running) and sticky flag
    int bc_a, bc_b;
    bit st_a, st_b;

`ifdef HAZARD_CTRL_PERF_EN
    logic [31:0] stall_a, flush_a;
    logic [3:0]  stall_b, flush_b;
    longint      m_stall_a, m_flush_a, m_stall_b, m_flush_b;
`endif

    always #5 clk = ~clk;

    hazard_ctrl u_main (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_rs1      (d_rs1),
        .d_rs2      (d_rs2),
        .d_uses_rs1 (d_uses_rs1),
        .d_uses_rs2 (d_uses_rs2),
        .e_rd       (e_rd),
        .e_is_load  (e_is_load),
        .e_redirect (e_redirect),
        .e_mdu_start(e_mdu_start),
        .mdu_done   (mdu_done),
        .f_enable   (out_a[7]),
        .fd_enable  (out_a[6]),
        .fd_flush   (out_a[5]),
        .de_enable  (out_a[4]),
        .de_flush   (out_a[3]),
        .em_flush   (out_a[2]),
        .mdu_busy   (out_a[1]),
        .mdu_timeout(out_a[0])
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .stall_cycles(stall_a),
        .flush_events(flush_a)
`endif
    );

    hazard_ctrl #(
        .MDU_TIMEOUT(4),
        .PERF_W     (4)
    ) u_wdt (
        .clk        (clk),
        .reset_n    (reset_n),
        .d_rs1      (d_rs1),
        .d_rs2      (d_rs2),
        .d_uses_rs1 (d_uses_rs1),
        .d_uses_rs2 (d_uses_rs2),
        .e_rd       (e_rd),
        .e_is_load  (e_is_load),
        .e_redirect (e_redirect),
        .e_mdu_start(e_mdu_start),
        .mdu_done   (mdu_done),
        .f_enable   (out_b[7]),
        .fd_enable  (out_b[6]),
        .fd_flush   (out_b[5]),
        .de_enable  (out_b[4]),
        .de_flush   (out_b[3]),
        .em_flush   (out_b[2]),
        .mdu_busy   (out_b[1]),
        .mdu_timeout(out_b[0])
`ifdef HAZARD_CTRL_PERF_EN
        ,
        .stall_cycles(stall_b),
        .flush_events(flush_b)
`endif
    );

    // expected {f_en, fd_en, fd_fl, de_en, de_fl, em_fl, busy, tmo}
    function automatic logic [7:0] expect_out(int bc, bit st, int tmo);
        bit f = 1, fde = 1, fdf = 0, dee = 1, def = 0, em = 0, t = st;
        bit hit;
        hit = e_is_load && e_rd != 0 &&
              ((d_uses_rs1 && d_rs1 == e_rd) || (d_uses_rs2 && d_rs2 == e_rd));
        if (bc == 0) begin
            if (e_redirect) begin
                fdf = 1; def = 1;
            end else if (e_mdu_start && !mdu_done) begin
                f = 0; fde = 0; dee = 0; em = 1;
            end else if (!e_mdu_start && hit) begin
                f = 0; fde = 0; def = 1;
            end
        end else if (!mdu_done) begin
            em = 1;
            if (bc >= tmo) t = 1;
            else begin f = 0; fde = 0; dee = 0; end
        end
        return {f, fde, fdf, dee, def, em, bc != 0, t};
    endfunction

    task automatic advance(inout int bc, inout bit st, input int tmo);
        if (bc == 0) begin
            if (!e_redirect && e_mdu_start && !mdu_done) bc = 1;
        end else if (mdu_done) begin
            bc = 0;
        end else if (bc >= tmo) begin
            st = 1; bc = 0;
        end else begin
            bc = bc + 1;
        end
    endtask

    task automatic check(string tag, logic [63:0] obs, logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s/%s observed=%0h expected=%0h", phase, tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        bc_a = 0; bc_b = 0; st_a = 0; st_b = 0;
`ifdef HAZARD_CTRL_PERF_EN
        m_stall_a = 0; m_flush_a = 0; m_stall_b = 0; m_flush_b = 0;
`endif
    endtask

    task automatic check_all();
        if (!reset_n) model_reset();
        check("main", 64'(out_a), 64'(expect_out(bc_a, st_a, 64)));
        check("wdt", 64'(out_b), 64'(expect_out(bc_b, st_b, 4)));
`ifdef HAZARD_CTRL_PERF_EN
        check("stall_a", 64'(stall_a), 64'(m_stall_a));
        check("flush_a", 64'(flush_a), 64'(m_flush_a));
        check("stall_b", 64'(stall_b), 64'(m_stall_b));
        check("flush_b", 64'(flush_b), 64'(m_flush_b));
`endif
    endtask

    task automatic model_clock();
        logic [7:0] ea, eb;
        if (!reset_n) begin
            model_reset();
            return;
        end
        ea = expect_out(bc_a, st_a, 64);
        eb = expect_out(bc_b, st_b, 4);
`ifdef HAZARD_CTRL_PERF_EN
        if (!ea[7] && m_stall_a < 64'hFFFF_FFFF) m_stall_a++;
        if (ea[5] && m_flush_a < 64'hFFFF_FFFF) m_flush_a++;
        if (!eb[7] && m_stall_b < 15) m_stall_b++;
        if (eb[5] && m_flush_b < 15) m_flush_b++;
`else
        if (ea === 8'hxx || eb === 8'hxx) $fatal(1, "model produced X");
`endif
        advance(bc_a, st_a, 64);
        advance(bc_b, st_b, 4);
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_clock();
        #1;
    endtask

    task automatic quiet();
        d_rs1 = 0; d_rs2 = 0; d_uses_rs1 = 0; d_uses_rs2 = 0;
        e_rd = 0; e_is_load = 0; e_redirect = 0;
        e_mdu_start = 0; mdu_done = 0;
    endtask

    initial begin
        quiet();
        reset_n = 0;
        model_reset();
        phase = "reset";
        #2;
        check_all();
        step();
        reset_n = 1;
        step();

        phase = "loaduse";
        e_is_load = 1; e_rd = 5; d_rs2 = 5; d_uses_rs2 = 1;
        step();
        e_is_load = 0;
        step();
        phase = "loaduse_x0";
        e_is_load = 1; e_rd = 0; d_rs2 = 0;
        step();
        phase = "redir_lu";
        e_rd = 7; d_rs1 = 7; d_uses_rs1 = 1; e_redirect = 1;
        step();
        quiet();
        step();

        phase = "mdu7";
        e_mdu_start = 1;
        step();
        e_mdu_start = 0;
        for (int i = 1; i < 7; i++) step();
        mdu_done = 1;
        step();
        mdu_done = 0;
        step();
        step();

        phase = "async_rst";
        e_mdu_start = 1;
        step();
        e_mdu_start = 0;
        step();
        step();
        #2 reset_n = 0;
        #1 check_all();
        step();
        reset_n = 1;
        step();

        phase = "wdt64";
        e_mdu_start = 1;
        step();
        e_mdu_start = 0;
        for (int i = 0; i < 70; i++) step();

        phase = "random";
        for (int i = 0; i < 3000; i++) begin
            d_rs1 = 5'($urandom_range(0, 3));
            d_rs2 = 5'($urandom_range(0, 3));
            e_rd = 5'($urandom_range(0, 3));
            d_uses_rs1 = 1'($urandom_range(0, 1));
            d_uses_rs2 = 1'($urandom_range(0, 1));
            e_is_load = 1'($urandom_range(0, 1));
            e_redirect = ($urandom_range(0, 99) < 15);
            e_mdu_start = ($urandom_range(0, 99) < 15);
            mdu_done = ($urandom_range(0, 99) < 25);
            reset_n = ($urandom_range(0, 199) != 0);
            step();
        end
        reset_n = 1;
        quiet();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
